data_mem_burst: RTL

- Parametrised successor of the single-cycle data memory: word-organised RAM behind a valid/ready request/response interface with programmable access latency.
- Serves two kinds of access. Single-word load/store uses RISC-V funct3 byte/half/word semantics. Cache-line burst refill (read) and writeback (write) serve the multicore cache controller.
- Sits between the cache controller/bus arbiter and backing storage.

---
 rtl/data_mem_burst_if.sv | 31 +++
 rtl/data_mem_burst.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_mem_burst_if.sv
// Request/response and burst-write channel bundle shared by the cache side
// (master) and the data memory (slave).
interface data_mem_burst_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_burst;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_last;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_burst, req_funct3, req_addr, req_wdata,
        output wvalid, wdata, rsp_ready,
        input  req_ready, wready, rsp_valid, rsp_rdata, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_burst, req_funct3, req_addr, req_wdata,
        input  wvalid, wdata, rsp_ready,
        output req_ready, wready, rsp_valid, rsp_rdata, rsp_last, rsp_err
    );
endinterface

// File: rtl/data_mem_burst.sv
// Word RAM with single load/store (funct3 lanes) and cache-line burst refill/writeback.
// Define MISALIGN_CHECK_EN to flag misaligned half/word single accesses as errors.
module data_mem_burst #(
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 4,
    parameter int RD_LATENCY = 2,
    parameter int INIT_INCR  = 1
) (
    input logic             clk,
    input logic             reset,
    data_mem_burst_if.slave bus
);
    localparam int IW  = $clog2(DEPTH);
    localparam int LWB = $clog2(LINE_WORDS);
    localparam int CW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, RESP} state_t;

    state_t          r_state, w_next;
    logic [31:0]     r_mem [DEPTH];
    logic            r_we, r_burst, r_err;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [IW-1:0]   r_idx;
    logic [31:0]     r_wdata, r_rdata;
    logic [CW-1:0]   r_lat;
    logic [LWB-1:0]  r_beat;

    logic [29:0]     w_widx_raw, w_widx;
    logic            w_range_err, w_size_err, w_misalign, w_err;
    logic            w_lat_done, w_beat_last, w_valid;
    logic [LWB-1:0]  w_beat_nxt;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01:   if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Range check uses the full word index so addresses past DEPTH are caught.
    assign w_widx_raw  = bus.req_addr[31:2];
    assign w_widx      = bus.req_burst ? (w_widx_raw & ~30'(LINE_WORDS - 1)) : w_widx_raw;
    assign w_range_err = ({2'b00, w_widx} >= 32'(DEPTH));

    always_comb begin
        w_size_err = 1'b0;
        if (!bus.req_burst) begin
            if (bus.req_we)
                w_size_err = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
            else
                w_size_err = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = !bus.req_burst &&
                        ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                         (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err       = w_range_err | w_size_err | w_misalign;
    assign w_lat_done  = (r_lat == CW'(RD_LATENCY - 1));
    assign w_beat_last = (r_beat == LWB'(LINE_WORDS - 1));
    assign w_beat_nxt  = r_beat + LWB'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = (bus.req_burst && bus.req_we) ? WBURST : WAIT;
            WAIT:    if (w_lat_done) w_next = r_burst ? RBURST : RESP;
            RBURST:  if (bus.rsp_ready && w_beat_last) w_next = IDLE;
            WBURST:  if (bus.wvalid && w_beat_last) w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_lat   <= '0;
            r_beat  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= (INIT_INCR != 0) ? 32'(i + 1) : 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_we     <= bus.req_we;
                    r_burst  <= bus.req_burst;
                    r_funct3 <= bus.req_funct3;
                    r_off    <= bus.req_addr[1:0];
                    r_idx    <= w_widx[IW-1:0];
                    r_wdata  <= bus.req_wdata;
                    r_err    <= w_err;
                    r_rdata  <= '0;
                    r_lat    <= '0;
                    r_beat   <= '0;
                end
                WAIT: begin
                    r_lat <= r_lat + CW'(1);
                    if (w_lat_done) begin
                        if (r_burst)
                            r_rdata <= r_err ? '0 : r_mem[r_idx];
                        else if (!r_err) begin
                            if (r_we)
                                r_mem[r_idx] <= store_merge(r_mem[r_idx], r_wdata, r_funct3, r_off);
                            else
                                r_rdata <= load_ext(r_mem[r_idx], r_funct3, r_off);
                        end
                    end
                end
                // Next beat is prefetched only on a handshake, so a stalled beat holds.
                RBURST: if (bus.rsp_ready) begin
                    r_beat  <= w_beat_nxt;
                    r_rdata <= r_err ? '0 : r_mem[{r_idx[IW-1:LWB], w_beat_nxt}];
                end
                WBURST: if (bus.wvalid) begin
                    if (!r_err) r_mem[{r_idx[IW-1:LWB], r_beat}] <= bus.wdata;
                    r_beat <= w_beat_nxt;
                end
                default: ;
            endcase
        end
    end

    assign w_valid       = !reset && (r_state == RBURST || r_state == RESP);
    assign bus.req_ready = !reset && (r_state == IDLE);
    assign bus.wready    = !reset && (r_state == WBURST);
    assign bus.rsp_valid = w_valid;
    assign bus.rsp_last  = w_valid && (r_state == RESP || w_beat_last);
    assign bus.rsp_err   = w_valid && r_err;
    assign bus.rsp_rdata = w_valid ? r_rdata : '0;
endmodule
